inst_queue: RTL
===============

Name: inst_queue

Overview:
- Circular instruction FIFO between the fetch unit and the issue unit.
- Buffers fetched instructions together with their PC and branch-prediction info.
- Presents the head entry in first-word-fall-through form, so the issue unit can decode it combinationally and pop it in the same cycle with iq_re.
- flush discards all entries on branch mispredict or ROB recovery.

Parameters:
- IQ_DEPTH, 16, number of entries; must be a power of two, at least 4.
- IQ_ADDR_WIDTH, 4, log2(IQ_DEPTH).
- IQ_AFULL_SLACK, 2, iq_almost_full asserts when free entries <= this value.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all entries.
- if_we  input  1  fetch push request.
- if_inst  input  32  fetched instruction.
- if_pc  input  32  PC of if_inst.
- if_pred  input  1  predicted-taken flag from fetch.
- if_pred_target  input  32  predicted next PC.
- iq_full  output  1  count == IQ_DEPTH.
- iq_almost_full  output  1  (IQ_DEPTH - count) <= IQ_AFULL_SLACK.
- iq_empty  output  1  count == 0.
- iq_count  output  IQ_ADDR_WIDTH+1  current occupancy.
- iq_inst  output  32  head instruction; 0 when empty.
- iq_pc  output  32  head PC; 0 when empty.
- iq_pred  output  1  head prediction flag; 0 when empty.
- iq_pred_target  output  32  head predicted target; 0 when empty.
- iq_re  input  1  issue unit pops the head this cycle.

Behaviour:
- Storage
  - IQ_DEPTH entries of {inst, pc, pred, pred_target}.
  - Pointers: head and tail (IQ_ADDR_WIDTH bits each, natural wrap from IQ_DEPTH-1 to 0), plus a count register (IQ_ADDR_WIDTH+1 bits).
- Reset (rst=1, asynchronous)
  - head=0, tail=0, count=0.
  - iq_empty=1, iq_full=0, iq_almost_full=0 (IQ_AFULL_SLACK < IQ_DEPTH).
  - iq_count=0; all head outputs 0.
  - Entry contents need not be cleared.
  - Reset mid-operation discards everything.
- Outputs
  - iq_empty, iq_full, iq_almost_full and iq_count derive combinationally from the count register only.
  - iq_empty, iq_full and iq_almost_full never depend on same-cycle if_we or iq_re.
  - Head outputs are a combinational read of entry[head], gated to 0 when iq_empty.
  - Zero-cycle fall-through from fetch is not provided: a push at edge N is visible at the head after edge N.
- Push and pop
  - push = if_we && !iq_full && !flush.
  - Push writes entry[tail] and increments tail.
  - Push while full is dropped silently. This holds even if a pop occurs in the same cycle; fetch must stall on iq_full or iq_almost_full.
  - pop = iq_re && !iq_empty && !flush.
  - Pop increments head.
  - iq_re while empty is ignored.
  - Simultaneous push and pop (not full, not empty): both occur, count unchanged.
  - When count==1, push and pop together leave count=1, and the new entry becomes the head.
- Count update
  - count += push - pop.
  - No overflow or underflow is possible given the gating above.
- Flush
  - Takes priority over push and pop in the same cycle.
  - Next edge: head=0, tail=0, count=0; the same-cycle push is discarded.
  - Flush while empty is harmless.
- Latency
  - Push to iq_empty deasserting: 1 cycle.
  - Pop to next entry visible: 1 cycle.
- Data integrity
  - Entries are never reordered.
  - The pred and pred_target fields travel unchanged with their instruction.

Test Plan:
- Reset, then push 3 entries (pc 0x0, 0x4, 0x8; inst 0x00100093, 0x00200113, 0x00308193), no pops:
  - Head shows pc=0x0, inst=0x00100093.
  - iq_count=3, iq_empty=0.
  - Pop three times: pcs come out 0x0, 0x4, 0x8 in order, then iq_empty=1 and the head outputs are 0.
- Fill 16 entries:
  - iq_almost_full asserts at count=14; iq_full=1 at count=16.
  - A 17th push with pc=0x40 is dropped.
  - Drain all 16: pcs are 0x0..0x3C, and 0x40 is absent.
- Occupancy 5, simultaneous push and pop every cycle for 20 cycles:
  - count stays 5 throughout.
  - Pointers wrap past 15→0.
  - Output pc sequence is strictly +4 with no gaps.
- Occupancy 1, simultaneous push (pc 0x100) and pop of pc 0xFC:
  - Next cycle: head pc=0x100, count=1.
- Occupancy 7, flush asserted together with if_we and iq_re:
  - Next cycle: iq_empty=1, count=0.
  - A following push with pc=0x200 appears at the head.
- rst asserted asynchronously between clock edges with occupancy 9:
  - iq_empty=1 and iq_count=0 immediately, before the next edge.
  - Pred fields test: push if_pred=1, if_pred_target=0x80; it pops with iq_pred=1, iq_pred_target=0x80.

Source files
------------

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Circular instruction FIFO between fetch and issue. Each entry holds
//   {inst, pc, pred, pred_target}. The head entry is presented combinationally
//   (first-word-fall-through) so issue can decode and pop it in one cycle.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous discard of all entries (wins over push/pop)
//   if_we, if_inst, if_pc, if_pred, if_pred_target
//                      fetch push request and payload
//   iq_full, iq_almost_full, iq_empty, iq_count
//                      occupancy status, derived from the count register only
//   iq_inst, iq_pc, iq_pred, iq_pred_target
//                      head entry, forced to 0 while empty
//   iq_re              issue pops the head this cycle
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int IQ_DEPTH       = 16,
    parameter int IQ_ADDR_WIDTH  = 4,
    parameter int IQ_AFULL_SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_we,
    input  logic [31:0]              if_inst,
    input  logic [31:0]              if_pc,
    input  logic                     if_pred,
    input  logic [31:0]              if_pred_target,
    output logic                     iq_full,
    output logic                     iq_almost_full,
    output logic                     iq_empty,
    output logic [IQ_ADDR_WIDTH:0]   iq_count,
    output logic [31:0]              iq_inst,
    output logic [31:0]              iq_pc,
    output logic                     iq_pred,
    output logic [31:0]              iq_pred_target,
    input  logic                     iq_re
);

    localparam logic [IQ_ADDR_WIDTH:0]   DEPTH = (IQ_ADDR_WIDTH+1)'(IQ_DEPTH);
    localparam logic [IQ_ADDR_WIDTH:0]   SLACK = (IQ_ADDR_WIDTH+1)'(IQ_AFULL_SLACK);
    localparam logic [IQ_ADDR_WIDTH-1:0] PTR_ONE = IQ_ADDR_WIDTH'(1);
    localparam logic [IQ_ADDR_WIDTH:0]   CNT_ONE = (IQ_ADDR_WIDTH+1)'(1);

    // Entry storage; contents are not reset, validity comes from count.
    logic [31:0] mem_inst   [IQ_DEPTH];
    logic [31:0] mem_pc     [IQ_DEPTH];
    logic        mem_pred   [IQ_DEPTH];
    logic [31:0] mem_target [IQ_DEPTH];

    logic [IQ_ADDR_WIDTH-1:0] head, tail;
    logic [IQ_ADDR_WIDTH:0]   count;
    logic [IQ_ADDR_WIDTH:0]   free_slots;
    logic                     push, pop;

    // Status comes from the registered count only, never from same-cycle
    // requests, so fetch/issue see a stable view for the whole cycle.
    assign free_slots     = DEPTH - count;
    assign iq_full        = (count == DEPTH);
    assign iq_empty       = (count == '0);
    assign iq_almost_full = (free_slots <= SLACK);
    assign iq_count       = count;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push = if_we && !iq_full && !flush;
    assign pop  = iq_re && !iq_empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail]   <= if_inst;
            mem_pc[tail]     <= if_pc;
            mem_pred[tail]   <= if_pred;
            mem_target[tail] <= if_pred_target;
        end
    end

    // Fall-through head read, gated so an empty queue shows all zeros.
    always_comb begin
        iq_inst        = '0;
        iq_pc          = '0;
        iq_pred        = 1'b0;
        iq_pred_target = '0;
        if (!iq_empty) begin
            iq_inst        = mem_inst[head];
            iq_pc          = mem_pc[head];
            iq_pred        = mem_pred[head];
            iq_pred_target = mem_target[head];
        end
    end

endmodule
